bcd_serial_sequencer: RTL

- Digit-serial controller for BCD add/subtract of two DIGITS-digit operands.
- Time-shares one single-digit BCD adder stage, processing one digit per clock, least significant digit first.
- Performs subtraction as A + 9's complement(B) + 1. A negative result triggers a second recomplement pass.
- Sits between the switch-input capture and the 7-segment display decode. Replaces the one-digit combinational add path with a sequenced multi-digit add/subtract.

---
 rtl/bcd_serial_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/bcd_serial_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bcd_serial_sequencer
// Description : Digit-serial BCD add/subtract. One shared single-digit adder,
//               LSD first; negative differences get a 10's-complement pass.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_sequencer #(
    parameter int DIGITS = 2
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [4*DIGITS-1:0]   a_bcd,
    input  logic [4*DIGITS-1:0]   b_bcd,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  carry_out,
    output logic                  negative,
    output logic                  err
);

    localparam int                 c_IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DIGITS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADD  = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_next;
    logic [4*DIGITS-1:0]  r_a;
    logic [4*DIGITS-1:0]  r_b;
    logic                 r_mode;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_carry;
    logic [4*DIGITS-1:0]  r_result;
    logic                 r_carry_out;
    logic                 r_negative;
    logic                 r_err;

    logic [2*DIGITS-1:0]  w_bad_vec;
    logic                 w_bad;
    logic [3:0]           w_a_dig;
    logic [3:0]           w_b_dig;
    logic [3:0]           w_r_dig;
    logic [3:0]           w_op_a;
    logic [3:0]           w_op_b;
    logic [4:0]           w_sum;
    logic                 w_dcarry;
    logic [3:0]           w_dsum;
    logic                 w_last;

    // Operand validity is judged on the live inputs so err is ready at acceptance.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit_chk
        assign w_bad_vec[2*g]   = (a_bcd[4*g +: 4] > 4'd9);
        assign w_bad_vec[2*g+1] = (b_bcd[4*g +: 4] > 4'd9);
    end
    assign w_bad = |w_bad_vec;

    always_comb begin
        w_a_dig = 4'd0;
        w_b_dig = 4'd0;
        w_r_dig = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_a_dig = r_a[4*i +: 4];
                w_b_dig = r_b[4*i +: 4];
                w_r_dig = r_result[4*i +: 4];
            end
        end
    end

    // FIX reuses the adder to form 9's complement of the partial result plus carry.
    assign w_op_a   = (r_state == c_FIX) ? (4'd9 - w_r_dig) : w_a_dig;
    assign w_op_b   = (r_state == c_FIX) ? 4'd0
                    : (r_mode ? (4'd9 - w_b_dig) : w_b_dig);
    assign w_sum    = {1'b0, w_op_a} + {1'b0, w_op_b} + {4'd0, r_carry};
    assign w_dcarry = (w_sum > 5'd9);
    assign w_dsum   = w_dcarry ? (w_sum[3:0] - 4'd10) : w_sum[3:0];
    assign w_last   = (r_idx == c_LAST_IDX);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_next = w_bad ? c_DONE : c_ADD;
                end
            end
            c_ADD: begin
                if (w_last) begin
                    w_next = (r_mode && !w_dcarry) ? c_FIX : c_DONE;
                end
            end
            c_FIX: begin
                if (w_last) begin
                    w_next = c_DONE;
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_mode      <= 1'b0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_negative  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_a         <= a_bcd;
                        r_b         <= b_bcd;
                        r_mode      <= mode;
                        r_idx       <= '0;
                        r_carry     <= mode;
                        r_result    <= '0;
                        r_carry_out <= 1'b0;
                        r_negative  <= 1'b0;
                        r_err       <= w_bad;
                    end
                end
                c_ADD: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (r_idx == c_IDX_W'(i)) begin
                            r_result[4*i +: 4] <= w_dsum;
                        end
                    end
                    r_carry <= w_dcarry;
                    if (w_last) begin
                        if (!r_mode) begin
                            r_carry_out <= w_dcarry;
                        end else if (!w_dcarry) begin
                            // No end-around carry: difference is negative, recomplement.
                            r_negative <= 1'b1;
                            r_idx      <= '0;
                            r_carry    <= 1'b1;
                        end
                    end else begin
                        r_idx <= r_idx + c_IDX_ONE;
                    end
                end
                c_FIX: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (r_idx == c_IDX_W'(i)) begin
                            r_result[4*i +: 4] <= w_dsum;
                        end
                    end
                    r_carry <= w_dcarry;
                    if (!w_last) begin
                        r_idx <= r_idx + c_IDX_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (r_state != c_IDLE);
    assign done      = (r_state == c_DONE);
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign negative  = r_negative;
    assign err       = r_err;

endmodule
`default_nettype wire
